onetosixteendemuxputblk_pipe4: RTL and testbench

Write-side counterpart of the pipelined 16-to-1 sub-block take mux in the ping-pong datapath. It accepts one 8-bit sub-block per cycle with a 4-bit slot index and scatters it into one of sixteen holding registers through a 4-stage pipeline. The write is qualified by the same ping-pong rules the take side uses: the slot is outside the pang window or pang is needed, and it is this side's turn. It also reports a one-cycle commit strobe and per-slot valid flags to the downstream assembler.

---
 rtl/onetosixteendemuxputblk_pipe4.sv | 151 +++++++++++++++
 tb/tb_onetosixteendemuxputblk_pipe4.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/onetosixteendemuxputblk_pipe4.sv
// Pipelined 1-to-16 sub-block scatter with ping-pong write qualification; 4 register stages sample-to-visible.
// No backpressure: one request accepted per cycle, dropped requests simply never commit.
module onetosixteendemuxputblk_pipe4 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vldi,
  input  logic [3:0]   sel,
  input  logic [W-1:0] subblki,
  input  logic         needpang,
  input  logic         myturnpingpong,
  input  logic [3:0]   needpangstartinc,
  input  logic [3:0]   needpangendinc,
  input  logic         clrall,
  output logic [W-1:0] subblko0,
  output logic [W-1:0] subblko1,
  output logic [W-1:0] subblko2,
  output logic [W-1:0] subblko3,
  output logic [W-1:0] subblko4,
  output logic [W-1:0] subblko5,
  output logic [W-1:0] subblko6,
  output logic [W-1:0] subblko7,
  output logic [W-1:0] subblko8,
  output logic [W-1:0] subblko9,
  output logic [W-1:0] subblko10,
  output logic [W-1:0] subblko11,
  output logic [W-1:0] subblko12,
  output logic [W-1:0] subblko13,
  output logic [W-1:0] subblko14,
  output logic [W-1:0] subblko15,
  output logic [15:0]  blkvalido,
  output logic         putblko,
  output logic [3:0]   putselo
);

  typedef struct packed {
    logic         vld;
    logic [3:0]   sel;
    logic [W-1:0] dat;
    logic         needpang;
    logic         myturn;
    logic         outwin;
  } p0_t;

  typedef struct packed {
    logic         vld;
    logic         put;
    logic [3:0]   sel;
    logic [W-1:0] dat;
    logic         myturn;
  } p1_t;

  typedef struct packed {
    logic         commit;
    logic [15:0]  we;
    logic [3:0]   sel;
    logic [W-1:0] dat;
  } p2_t;

  p0_t p0_q;
  p1_t p1_q;
  p2_t p2_q;

  logic         outwin;
  logic         commit_d;
  logic [15:0]  we_d;
  logic [W-1:0] slot_q [16];

  // An inverted window (start > end) makes this true for every slot.
  assign outwin = (sel < needpangstartinc) || (sel > needpangendinc);

  always_comb begin
    commit_d = p1_q.put && p1_q.myturn && p1_q.vld;
    we_d     = '0;
    if (commit_d) begin
      we_d[p1_q.sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      p0_q.vld      <= vldi;
      p0_q.sel      <= sel;
      p0_q.dat      <= subblki;
      p0_q.needpang <= needpang;
      p0_q.myturn   <= myturnpingpong;
      p0_q.outwin   <= outwin;

      p1_q.vld    <= p0_q.vld;
      p1_q.put    <= p0_q.outwin || p0_q.needpang;
      p1_q.sel    <= p0_q.sel;
      p1_q.dat    <= p0_q.dat;
      p1_q.myturn <= p0_q.myturn;

      p2_q.commit <= commit_d;
      p2_q.we     <= we_d;
      p2_q.sel    <= p1_q.sel;
      p2_q.dat    <= p1_q.dat;
    end
  end

  // clrall is not pipelined: it acts on the edge it is sampled, and a commit on that edge still sets its bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      blkvalido <= '0;
      putblko   <= 1'b0;
      putselo   <= '0;
      for (int i = 0; i < 16; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      if (clrall) begin
        blkvalido <= p2_q.we;
      end else begin
        blkvalido <= blkvalido | p2_q.we;
      end
      putblko <= p2_q.commit;
      if (p2_q.commit) begin
        putselo <= p2_q.sel;
      end
      for (int i = 0; i < 16; i++) begin
        if (p2_q.we[i]) begin
          slot_q[i] <= p2_q.dat;
        end
      end
    end
  end

  assign subblko0  = slot_q[0];
  assign subblko1  = slot_q[1];
  assign subblko2  = slot_q[2];
  assign subblko3  = slot_q[3];
  assign subblko4  = slot_q[4];
  assign subblko5  = slot_q[5];
  assign subblko6  = slot_q[6];
  assign subblko7  = slot_q[7];
  assign subblko8  = slot_q[8];
  assign subblko9  = slot_q[9];
  assign subblko10 = slot_q[10];
  assign subblko11 = slot_q[11];
  assign subblko12 = slot_q[12];
  assign subblko13 = slot_q[13];
  assign subblko14 = slot_q[14];
  assign subblko15 = slot_q[15];

endmodule

// File: tb/tb_onetosixteendemuxputblk_pipe4.sv
// Bench for onetosixteendemuxputblk_pipe4: directed writes, expected commits queued and checked by a monitor.
module tb_onetosixteendemuxputblk_pipe4;

  logic            clk;
  logic            reset;
  logic            vldi;
  logic [3:0]      sel;
  logic [7:0]      subblki;
  logic            needpang;
  logic            myturnpingpong;
  logic [3:0]      needpangstartinc;
  logic [3:0]      needpangendinc;
  logic            clrall;
  logic [15:0][7:0] so;
  logic [15:0]     blkvalido;
  logic            putblko;
  logic [3:0]      putselo;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] dat;
    int         edge_n;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   ecount    = 0;
  int   pulse_cnt = 0;

  onetosixteendemuxputblk_pipe4 #(.W(8)) dut (
    .clk(clk), .reset(reset), .vldi(vldi), .sel(sel), .subblki(subblki),
    .needpang(needpang), .myturnpingpong(myturnpingpong),
    .needpangstartinc(needpangstartinc), .needpangendinc(needpangendinc),
    .clrall(clrall),
    .subblko0(so[0]), .subblko1(so[1]), .subblko2(so[2]), .subblko3(so[3]),
    .subblko4(so[4]), .subblko5(so[5]), .subblko6(so[6]), .subblko7(so[7]),
    .subblko8(so[8]), .subblko9(so[9]), .subblko10(so[10]), .subblko11(so[11]),
    .subblko12(so[12]), .subblko13(so[13]), .subblko14(so[14]), .subblko15(so[15]),
    .blkvalido(blkvalido), .putblko(putblko), .putselo(putselo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at edge %0d", name, act, exp, ecount);
    end
  endtask

  // Drive one request at the falling edge; it is sampled on the next rising edge.
  task automatic drive(input logic v, input logic [3:0] s, input logic [7:0] d,
                       input logic np, input logic mt, input logic expc);
    @(negedge clk);
    vldi = v; sel = s; subblki = d; needpang = np; myturnpingpong = mt;
    if (expc) q.push_back('{sel: s, dat: d, edge_n: ecount + 4});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every pulse must match the oldest queued write, at its expected edge.
  always @(negedge clk) begin
    if (putblko) begin
      pulse_cnt++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse putselo=%0d at edge %0d", putselo, ecount);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("put_sel", 32'(putselo), 32'(e.sel));
        chk("put_edge", 32'(ecount), 32'(e.edge_n));
        chk("put_data", 32'(so[putselo]), 32'(e.dat));
        chk("put_valid", 32'(blkvalido[putselo]), 32'd1);
      end
    end else if (q.size() > 0 && ecount >= q[0].edge_n) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_pulse sel=%0d expected at edge %0d", e.sel, e.edge_n);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1);
  end

  int pc0;

  initial begin
    reset = 1'b1; vldi = 1'b0; sel = '0; subblki = '0; needpang = 1'b0;
    myturnpingpong = 1'b0; needpangstartinc = 4'd9; needpangendinc = 4'd3; clrall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_blkvalid", 32'(blkvalido), 32'h0);
    chk("rst_putblk", 32'(putblko), 32'h0);
    chk("rst_putsel", 32'(putselo), 32'h0);
    reset = 1'b0;

    // Populate a few slots, then one reset edge must clear everything.
    drive(1'b1, 4'd1, 8'h55, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'd3, 8'h66, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'd12, 8'h77, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("pre_rst_valid", 32'(blkvalido), 32'h100A);
    @(negedge clk);
    reset = 1'b1; vldi = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) chk($sformatf("rst_slot%0d", i), 32'(so[i]), 32'h0);
    chk("rst2_blkvalid", 32'(blkvalido), 32'h0);
    chk("rst2_putblk", 32'(putblko), 32'h0);

    // Window 4..11: sel=2 outside (written), sel=7 inside (dropped).
    needpangstartinc = 4'd4; needpangendinc = 4'd11;
    drive(1'b1, 4'd2, 8'hA5, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'd7, 8'h3C, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("win_slot2", 32'(so[2]), 32'hA5);
    chk("win_slot7", 32'(so[7]), 32'h0);
    chk("win_valid", 32'(blkvalido), 32'h0004);
    chk("win_putsel_hold", 32'(putselo), 32'd2);

    drive(1'b1, 4'd7, 8'h3C, 1'b1, 1'b1, 1'b1);
    idle(4);
    chk("np_slot7", 32'(so[7]), 32'h3C);
    chk("np_valid", 32'(blkvalido), 32'h0084);

    // Inclusive window edges are dropped, just outside is written.
    drive(1'b1, 4'd4, 8'h44, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 4'd11, 8'hBB, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 4'd12, 8'hC1, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("edge_slot4", 32'(so[4]), 32'h0);
    chk("edge_slot11", 32'(so[11]), 32'h0);
    chk("edge_valid", 32'(blkvalido), 32'h1084);

    // myturn travels with its own request.
    drive(1'b1, 4'd0, 8'h11, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'd1, 8'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd13, 8'hD1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd14, 8'hE1, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("mt_slot0", 32'(so[0]), 32'h11);
    chk("mt_slot1", 32'(so[1]), 32'h0);
    chk("mt_slot13", 32'(so[13]), 32'h0);
    chk("mt_valid", 32'(blkvalido), 32'h5085);

    // Inverted window: everything writable, 16 back-to-back commits.
    needpangstartinc = 4'd9; needpangendinc = 4'd3;
    pc0 = pulse_cnt;
    for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 8'(8'h80 + i), 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("inv_valid", 32'(blkvalido), 32'hFFFF);
    chk("inv_pulses", 32'(pulse_cnt - pc0), 32'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("inv_slot%0d", i), 32'(so[i]), 32'(8'h80 + i));

    // Same slot twice in a row: later data stays.
    drive(1'b1, 4'd6, 8'h61, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'd6, 8'h62, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("b2b_slot6", 32'(so[6]), 32'h62);

    // clrall on the same edge the sel=5 write lands.
    drive(1'b1, 4'd5, 8'h5A, 1'b0, 1'b1, 1'b1);
    idle(2);
    @(negedge clk);
    vldi = 1'b0; clrall = 1'b1;
    @(negedge clk);
    clrall = 1'b0;
    chk("clr_valid", 32'(blkvalido), 32'h0020);
    chk("clr_slot5", 32'(so[5]), 32'h5A);
    chk("clr_data_kept", 32'(so[0]), 32'h80);

    // Reset one cycle after sampling discards the in-flight request.
    drive(1'b1, 4'd9, 8'h99, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    vldi = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 4'd3, 8'h33, 1'b0, 1'b1, 1'b1);
    idle(5);
    chk("midrst_slot9", 32'(so[9]), 32'h0);
    chk("midrst_slot3", 32'(so[3]), 32'h33);
    chk("midrst_valid", 32'(blkvalido), 32'h0008);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
